mix_column_seq_ctrl: RTL

Sequencing controller that applies the AES MixColumns (or InvMixColumns) transform to a full 4x4-byte state. It reuses COLS_PER_CYCLE single-column GF(2^8) matrix units over successive cycles rather than instantiating a full-state combinational array. It sits between the ShiftRows stage and AddRoundKey in the round pipeline. It uses a valid/ready handshake on both sides and has a bypass used for the final AES round.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/mix_column_seq_ctrl_if.sv | 29 ++
 rtl/mix_column_unit.sv | 33 +++
 rtl/mix_column_seq_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES MixColumns types, coefficient tables and GF(2^8) helpers.
//   byte_t / col_t / state_t : state layout is state[c][r], column c, row r
//   fsm_t                    : sequencing controller states
//   MIX_FWD / MIX_INV        : row r of the matrix, entry [j] multiplies input row j
//   xtime / gf_mul           : multiply by x, and by one of 01/02/03/09/0B/0D/0E
package aes_pkg;

    typedef logic [7:0]             byte_t;
    typedef logic [3:0][7:0]        col_t;
    typedef logic [3:0][3:0][7:0]   state_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } fsm_t;

    // Packed concatenation lists entry [3] first, so each row reads right-to-left.
    localparam col_t MIX_FWD [4] = '{
        {8'h01, 8'h01, 8'h03, 8'h02},
        {8'h01, 8'h03, 8'h02, 8'h01},
        {8'h03, 8'h02, 8'h01, 8'h01},
        {8'h02, 8'h01, 8'h01, 8'h03}
    };

    localparam col_t MIX_INV [4] = '{
        {8'h09, 8'h0d, 8'h0b, 8'h0e},
        {8'h0d, 8'h0b, 8'h0e, 8'h09},
        {8'h0b, 8'h0e, 8'h09, 8'h0d},
        {8'h0e, 8'h09, 8'h0d, 8'h0b}
    };

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Products restricted to the coefficients that appear in the two matrices.
    function automatic byte_t gf_mul(input byte_t b, input byte_t coef);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (coef)
            8'h01:   gf_mul = b;
            8'h02:   gf_mul = x2;
            8'h03:   gf_mul = x2 ^ b;
            8'h09:   gf_mul = x8 ^ b;
            8'h0b:   gf_mul = x8 ^ x2 ^ b;
            8'h0d:   gf_mul = x8 ^ x4 ^ b;
            8'h0e:   gf_mul = x8 ^ x4 ^ x2;
            default: gf_mul = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mix_column_seq_ctrl_if.sv
// Handshake bundle for the MixColumns sequencing controller.
//   in_valid/in_ready/in_state/in_inverse/in_bypass : upstream (ShiftRows) side
//   out_valid/out_ready/out_state                   : downstream (AddRoundKey) side
//   busy/col_idx                                    : status and debug
// master = the environment driving states in; slave = the controller.
interface mix_column_seq_ctrl_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    state_t     in_state;
    logic       in_inverse;
    logic       in_bypass;
    logic       out_valid;
    logic       out_ready;
    state_t     out_state;
    logic       busy;
    logic [1:0] col_idx;

    modport master (
        output in_valid, in_state, in_inverse, in_bypass, out_ready,
        input  in_ready, out_valid, out_state, busy, col_idx
    );

    modport slave (
        input  in_valid, in_state, in_inverse, in_bypass, out_ready,
        output in_ready, out_valid, out_state, busy, col_idx
    );
endinterface

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns.
//   col_in  : one state column, rows 0..3
//   inverse : 1 selects the inverse matrix
//   col_out : transformed column
module mix_column_unit
    import aes_pkg::*;
(
    input  col_t col_in,
    input  logic inverse,
    output col_t col_out
);

    // Each output row is the XOR of four GF products along one matrix row.
    function automatic col_t mix(input col_t c, input logic inv);
        col_t  res;
        byte_t coef;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                coef   = inv ? MIX_INV[r][j] : MIX_FWD[r][j];
                res[r] = res[r] ^ gf_mul(c[j], coef);
            end
        end
        return res;
    endfunction

    // Column transform.
    always_comb begin
        col_out = '0;
        col_out = mix(col_in, inverse);
    end

endmodule

// File: rtl/mix_column_seq_ctrl.sv
// MixColumns sequencing controller: transforms a 4x4-byte state by passing
// COLS_PER_CYCLE columns per cycle through shared column units, writing each
// result back into the working register in place.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of mix_column_seq_ctrl_if (handshakes, state,
//                mode bits, busy, col_idx)
// Latency accept -> out_valid is 4/COLS_PER_CYCLE + 1 cycles, 1 in bypass.
module mix_column_seq_ctrl
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mix_column_seq_ctrl_if.slave  bus
);

    localparam int         N_COMPUTE = 4 / COLS_PER_CYCLE;
    // col_idx value during the final compute cycle of a state.
    localparam logic [1:0] LAST_COL  = 2'((N_COMPUTE - 1) * COLS_PER_CYCLE);
    // Truncates to 0 when all four columns go in one cycle.
    localparam logic [1:0] COL_STEP  = 2'(COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_column_seq_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_t       state_r;
    fsm_t       state_s;
    state_t     work_r;
    state_t     work_s;
    logic       inv_r;
    logic [1:0] col_r;
    logic [1:0] col_s;
    // Holds in_ready low until the first clock after reset release.
    logic       rdy_en_r;
    logic       in_ready_s;
    logic       out_valid_s;
    logic       busy_s;
    logic       accept_s;
    col_t       unit_in_s  [COLS_PER_CYCLE];
    col_t       unit_out_s [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        assign unit_in_s[g] = work_r[col_r + 2'(g)];

        mix_column_unit u_unit (
            .col_in  (unit_in_s[g]),
            .inverse (inv_r),
            .col_out (unit_out_s[g])
        );
    end

    assign accept_s = bus.in_valid & in_ready_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; DONE may take a new state in the same cycle it hands one off.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = bus.in_bypass ? ST_DONE : ST_COMPUTE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (col_r == LAST_COL) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_s = bus.in_bypass ? ST_DONE : ST_COMPUTE;
                end else if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = rdy_en_r;
            end
            ST_COMPUTE: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                in_ready_s  = bus.out_ready;
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    // Working-register and column-index update: capture on accept, in-place write-back while computing.
    always_comb begin
        work_s = work_r;
        col_s  = 2'd0;
        if (accept_s) begin
            work_s = bus.in_state;
            col_s  = 2'd0;
        end else if (state_r == ST_COMPUTE) begin
            for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                work_s[col_r + 2'(i)] = unit_out_s[i];
            end
            // Wraps to 0 on the last compute cycle.
            col_s = col_r + COL_STEP;
        end else begin
            col_s = 2'd0;
        end
    end

    // Datapath registers; mode bit is sampled only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r   <= '0;
            col_r    <= 2'd0;
            inv_r    <= 1'b0;
            rdy_en_r <= 1'b0;
        end else begin
            work_r   <= work_s;
            col_r    <= col_s;
            rdy_en_r <= 1'b1;
            if (accept_s) begin
                inv_r <= bus.in_inverse;
            end else begin
                inv_r <= inv_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_state = work_r;
    assign bus.busy      = busy_s;
    assign bus.col_idx   = col_r;

endmodule
